// File: rtl/openram_arb_pkg.sv
// -----------------------------------------------------------------------------
// openram_arb_pkg
// Shared types and constants for the dual-port OpenRAM arbiter.
//   req_tag_e  : requester identity carried through the read-return pipeline
//   src_tag_t  : {valid, requester} tag travelling alongside each SRAM read
//   RD_LAT     : grant-to-rvalid latency in cycles
//   PORT_RW/R  : indices of the read/write port (0) and read-only port (1)
//   CNT_W      : width of the optional performance counters
// -----------------------------------------------------------------------------
package openram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_tag_e;

  typedef struct packed {
    logic     vld;
    req_tag_e src;
  } src_tag_t;

  localparam int RD_LAT    = 3;
  localparam int PORT_RW   = 0;
  localparam int PORT_R    = 1;
  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/openram_rr_arb2.sv
// -----------------------------------------------------------------------------
// openram_rr_arb2
// Two-way round-robin picker used to serialize writes onto SRAM port 0.
// A single request is granted directly and leaves the pointer alone; when both
// bits request, the pointer's requester wins and the pointer moves to the
// loser so the next conflict goes the other way.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (pointer returns to requester A)
//   req_i   : [0] = requester A, [1] = requester B
//   gnt_o   : one-hot grant (combinational)
// -----------------------------------------------------------------------------
module openram_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  import openram_arb_pkg::*;

  req_tag_e ptr_q;
  req_tag_e ptr_d;

  always_comb begin
    gnt_o = req_i;
    ptr_d = ptr_q;
    if (&req_i) begin
      gnt_o = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
      ptr_d = (ptr_q == REQ_A) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/openram_dp_arbiter.sv
// -----------------------------------------------------------------------------
// openram_dp_arbiter
// Shares a dual-port OpenRAM macro (port 0 read/write, port 1 read-only)
// between requester A (Wishbone host wrapper) and requester B (on-chip test
// sequencer). Concurrent reads are split across both ports, a write always
// owns port 0 and pushes a concurrent read onto port 1, and two writes are
// serialized by a round-robin picker. Read data returns RD_LAT cycles after
// the grant, steered by a {valid, requester} tag that follows each port.
//
// Optional feature macro: OPENRAM_ARB_PERF_EN
//   When defined, adds saturating 16-bit counters a_gnt_cnt_o, b_gnt_cnt_o
//   (grants per requester) and conflict_cnt_o (both-write stalls).
//
// Ports:
//   wb_clk_i, wb_rst_ni            : clock, synchronous active-low reset
//   {a,b}_req_i/_we_i/_wmask_i/
//   {a,b}_addr_i/_wdata_i          : requester command, held until granted
//   {a,b}_gnt_o                    : command accepted this cycle (comb.)
//   {a,b}_rvalid_o/_rdata_o        : read return, rdata held between pulses
//   ram_clk0/csb0/web0/wmask0/
//   ram_addr0/dout0, ram_din0      : SRAM port 0 (RW)
//   ram_clk1/csb1/addr1, ram_din1  : SRAM port 1 (R)
// -----------------------------------------------------------------------------
module openram_dp_arbiter
  import openram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [WMASK_WIDTH-1:0] a_wmask_i,
  input  logic [ADDR_WIDTH-1:0]  a_addr_i,
  input  logic [DATA_WIDTH-1:0]  a_wdata_i,
  output logic                   a_gnt_o,
  output logic                   a_rvalid_o,
  output logic [DATA_WIDTH-1:0]  a_rdata_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [WMASK_WIDTH-1:0] b_wmask_i,
  input  logic [ADDR_WIDTH-1:0]  b_addr_i,
  input  logic [DATA_WIDTH-1:0]  b_wdata_i,
  output logic                   b_gnt_o,
  output logic                   b_rvalid_o,
  output logic [DATA_WIDTH-1:0]  b_rdata_o,
  output logic                   ram_clk0,
  output logic                   ram_csb0,
  output logic                   ram_web0,
  output logic [WMASK_WIDTH-1:0] ram_wmask0,
  output logic [ADDR_WIDTH-1:0]  ram_addr0,
  output logic [DATA_WIDTH-1:0]  ram_dout0,
  input  logic [DATA_WIDTH-1:0]  ram_din0,
  output logic                   ram_clk1,
  output logic                   ram_csb1,
  output logic [ADDR_WIDTH-1:0]  ram_addr1,
  input  logic [DATA_WIDTH-1:0]  ram_din1
`ifdef OPENRAM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]       a_gnt_cnt_o,
  output logic [CNT_W-1:0]       b_gnt_cnt_o,
  output logic [CNT_W-1:0]       conflict_cnt_o
`endif
);

  // Tag stages between grant and the rvalid register.
  localparam int TAG_STAGES = RD_LAT - 1;

  assign ram_clk0 = wb_clk_i;
  assign ram_clk1 = wb_clk_i;

  // Requests are masked during reset so nothing is granted and the
  // round-robin pointer cannot move.
  logic a_req;
  logic b_req;
  assign a_req = a_req_i & wb_rst_ni;
  assign b_req = b_req_i & wb_rst_ni;

  logic [1:0] wr_req;
  logic [1:0] wr_gnt;
  assign wr_req = {b_req & b_we_i, a_req & a_we_i};

  openram_rr_arb2 u_rr_arb (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .req_i  (wr_req),
    .gnt_o  (wr_gnt)
  );

  // Reads are always granted; a write is granted only if the picker says so.
  assign a_gnt_o = a_req & (~a_we_i | wr_gnt[0]);
  assign b_gnt_o = b_req & (~b_we_i | wr_gnt[1]);

  // Port steering: B owns port 0 when it is the granted writer or the only
  // grant; otherwise A owns port 0. When both are granted, the requester not
  // on port 0 is necessarily a reader and goes to port 1.
  logic rw_sel_b;
  logic rw_vld;
  logic rw_we;
  logic ro_vld;
  assign rw_sel_b = b_gnt_o & (b_we_i | ~a_gnt_o);
  assign rw_vld   = a_gnt_o | b_gnt_o;
  assign rw_we    = rw_sel_b ? b_we_i : a_we_i;
  assign ro_vld   = a_gnt_o & b_gnt_o;

  logic                   csb0_q,   csb0_d;
  logic                   web0_q,   web0_d;
  logic [WMASK_WIDTH-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]  addr0_q,  addr0_d;
  logic [DATA_WIDTH-1:0]  dout0_q,  dout0_d;
  logic                   csb1_q,   csb1_d;
  logic [ADDR_WIDTH-1:0]  addr1_q,  addr1_d;

  // Grant cycle -> SRAM pins. Idle ports deselect and keep their address.
  always_comb begin
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    dout0_d  = dout0_q;
    csb1_d   = 1'b1;
    addr1_d  = addr1_q;
    if (rw_vld) begin
      csb0_d  = 1'b0;
      web0_d  = ~rw_we;
      addr0_d = rw_sel_b ? b_addr_i : a_addr_i;
      if (rw_we) begin
        wmask0_d = rw_sel_b ? b_wmask_i : a_wmask_i;
        dout0_d  = rw_sel_b ? b_wdata_i : a_wdata_i;
      end
    end
    if (ro_vld) begin
      csb1_d  = 1'b0;
      addr1_d = rw_sel_b ? a_addr_i : b_addr_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      dout0_q  <= '0;
      csb1_q   <= 1'b1;
      addr1_q  <= '0;
    end else begin
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      dout0_q  <= dout0_d;
      csb1_q   <= csb1_d;
      addr1_q  <= addr1_d;
    end
  end

  assign ram_csb0   = csb0_q;
  assign ram_web0   = web0_q;
  assign ram_wmask0 = wmask0_q;
  assign ram_addr0  = addr0_q;
  assign ram_dout0  = dout0_q;
  assign ram_csb1   = csb1_q;
  assign ram_addr1  = addr1_q;

  // Source tags enter alongside the command; writes carry no valid tag.
  src_tag_t tag_in [NUM_PORTS];

  always_comb begin
    tag_in[PORT_RW].vld = rw_vld & ~rw_we;
    tag_in[PORT_RW].src = rw_sel_b ? REQ_B : REQ_A;
    tag_in[PORT_R].vld  = ro_vld;
    tag_in[PORT_R].src  = rw_sel_b ? REQ_A : REQ_B;
  end

  // Tag shift register: stage 0 is aligned with the pins, the last stage
  // with the cycle in which the SRAM drives its read data.
  src_tag_t tag_pipe_q [NUM_PORTS][TAG_STAGES];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int s = 0; s < TAG_STAGES; s++) begin
          tag_pipe_q[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        tag_pipe_q[p][0] <= tag_in[p];
        for (int s = 1; s < TAG_STAGES; s++) begin
          tag_pipe_q[p][s] <= tag_pipe_q[p][s-1];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] ram_din [NUM_PORTS];
  assign ram_din[PORT_RW] = ram_din0;
  assign ram_din[PORT_R]  = ram_din1;

  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q,  a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q,  b_rdata_d;

  // SRAM data -> requester outputs. One requester never has two reads
  // returning in the same cycle, so at most one port matches each side.
  always_comb begin
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (tag_pipe_q[p][TAG_STAGES-1].vld) begin
        if (tag_pipe_q[p][TAG_STAGES-1].src == REQ_A) begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = ram_din[p];
        end else begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = ram_din[p];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;

`ifdef OPENRAM_ARB_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  logic [CNT_W-1:0] a_gnt_cnt_q,    a_gnt_cnt_d;
  logic [CNT_W-1:0] b_gnt_cnt_q,    b_gnt_cnt_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  assign a_gnt_cnt_d    = sat_inc(a_gnt_cnt_q, a_gnt_o);
  assign b_gnt_cnt_d    = sat_inc(b_gnt_cnt_q, b_gnt_o);
  assign conflict_cnt_d = sat_inc(conflict_cnt_q, &wr_req);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      a_gnt_cnt_q    <= '0;
      b_gnt_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      a_gnt_cnt_q    <= a_gnt_cnt_d;
      b_gnt_cnt_q    <= b_gnt_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign a_gnt_cnt_o    = a_gnt_cnt_q;
  assign b_gnt_cnt_o    = b_gnt_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
